// File: rtl/wb64_to_wb16_bridge.sv
// rtl/wb64_to_wb16_bridge.sv - 64-bit to 16-bit Wishbone-style width bridge
module wb64_to_wb16_bridge (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:3] s_adr_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [7:0]  s_sel_i,
  input  logic        s_vpa_i,
  input  logic [63:0] s_dat_i,
  output logic        s_ack_o,
  output logic [63:0] s_dat_o,
  output logic [63:1] m_adr_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  output logic        m_vpa_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:3] adr_q;
  logic        we_q;
  logic        vpa_q;
  logic [7:0]  sel_q;
  logic [63:0] wdat_q;
  logic [63:0] rdat_q;
  logic [1:0]  lane_q;

  logic        req;
  logic        xfer;
  logic [7:0]  sel_rest;

  // Lowest halfword lane that has any byte enabled; 0 when none is.
  function automatic logic [1:0] first_lane(input logic [7:0] sel);
    logic [1:0] lane;
    lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (sel[2*k +: 2] != 2'b00) lane = 2'(k);
    end
    return lane;
  endfunction

  assign req      = s_cyc_i & s_stb_i;
  assign xfer     = (state_q == XFER);
  // Working byte enables once the current beat is retired.
  assign sel_rest = sel_q & ~(8'b0000_0011 << {lane_q, 1'b0});

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; an abort wins over a coincident narrow ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) state_d = (s_sel_i == 8'h00) ? DONE : XFER;
      end
      XFER: begin
        if (!s_cyc_i)                        state_d = IDLE;
        else if (m_ack_i && sel_rest == 8'h00) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and per-beat bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      adr_q  <= '0;
      we_q   <= 1'b0;
      vpa_q  <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      lane_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            adr_q  <= s_adr_i;
            we_q   <= s_we_i;
            vpa_q  <= s_vpa_i;
            sel_q  <= s_sel_i;
            wdat_q <= s_dat_i;
            rdat_q <= '0;
            lane_q <= first_lane(s_sel_i);
          end
        end
        XFER: begin
          if (s_cyc_i && m_ack_i) begin
            if (!we_q) rdat_q[{lane_q, 4'b0000} +: 16] <= m_dat_i;
            sel_q  <= sel_rest;
            lane_q <= first_lane(sel_rest);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; narrow fields are zero outside a beat.
  always_comb begin
    m_cyc_o = xfer;
    m_stb_o = xfer;
    m_adr_o = xfer ? {adr_q, lane_q} : 63'd0;
    m_we_o  = xfer & we_q;
    m_vpa_o = xfer & vpa_q;
    m_sel_o = xfer ? sel_q[{lane_q, 1'b0} +: 2] : 2'b00;
    m_dat_o = xfer ? wdat_q[{lane_q, 4'b0000} +: 16] : 16'h0000;
    s_ack_o = (state_q == DONE);
    s_dat_o = (state_q == DONE) ? rdat_q : 64'd0;
  end

endmodule
